// File: rtl/apple1_ram_pkg.sv
// apple1_ram_pkg
// Shared definitions for the Apple-1 RAM arbiter: the arbiter FSM state
// encoding, default address width and loader FIFO depth, and the loader
// write entry layout (address + data).
package apple1_ram_pkg;

    localparam int RAM_ADDR_W    = 16;
    localparam int LD_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CPU_SETUP  = 2'd1,
        ST_CPU_COMMIT = 2'd2,
        ST_LOAD_WR    = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [RAM_ADDR_W-1:0] addr;
        logic [7:0]            data;
    } ld_entry_t;

endpackage

// File: rtl/apple1_ld_fifo.sv
// apple1_ld_fifo
// Synchronous FIFO that buffers loader RAM writes so host bursts never wait
// on the CPU. Single clock (clk7), asynchronous active-low reset (reset_n).
// Reset discards contents by clearing the pointers and the fill count.
//
// Ports:
//   clk7, reset_n   clock and asynchronous active-low reset
//   push, wdata     write one entry (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   rdata           current head entry
//   full, empty     fill status, decoded from the registered count
//   count           number of stored entries
module apple1_ld_fifo
    import apple1_ram_pkg::*;
#(
    parameter int DEPTH = LD_FIFO_DEPTH,
    parameter int WIDTH = RAM_ADDR_W + 8
) (
    input  logic                   clk7,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk7 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk7) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/apple1_ram_arbiter.sv
// apple1_ram_arbiter
// Shares the synchronous system RAM between the 6502 core and a buffered
// loader write port, and produces the CPU clock enable. A CPU bus cycle takes
// CPU_SETUP (address/read strobe) then CPU_COMMIT (clken, write strobe, read
// capture). Loader writes drain from a FIFO one per LOAD_WR slot.
//
// Build option: define RAM_ARB_CPU_PRIORITY_EN to make the CPU always win
// arbitration; otherwise owners alternate round-robin on contention.
//
// Ports:
//   clk7, reset_n                      clock, asynchronous active-low reset
//   cpu_tick                           request one CPU bus cycle
//   cpu_addr/cpu_dout/cpu_ram_rd/_wr   core RAM interface
//   cpu_ram_dout                       registered read data to the core
//   cpu_clken                          one pulse per granted CPU cycle
//   cpu_overrun                        sticky: tick arrived while one pending
//   ld_valid/ld_ready/ld_addr/ld_data  loader write handshake
//   ld_busy                            loader writes queued or in progress
//   mem_addr/mem_din/mem_rd/mem_we     RAM command
//   mem_dout                           RAM read data, one clock after mem_rd
//
// state          | meaning
// ST_IDLE        | no RAM access; arbitrate CPU vs loader
// ST_CPU_SETUP   | CPU address on RAM, read strobe if reading
// ST_CPU_COMMIT  | cpu_clken, write strobe or read-data capture
// ST_LOAD_WR     | write FIFO head to RAM, pop FIFO
module apple1_ram_arbiter
    import apple1_ram_pkg::*;
#(
    parameter int FIFO_DEPTH = LD_FIFO_DEPTH,
    parameter int ADDR_W     = RAM_ADDR_W
) (
    input  logic              clk7,
    input  logic              reset_n,
    input  logic              cpu_tick,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_ram_rd,
    input  logic              cpu_ram_wr,
    output logic [7:0]        cpu_ram_dout,
    output logic              cpu_clken,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_busy,
    output logic              cpu_overrun,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_rd,
    output logic              mem_we,
    input  logic [7:0]        mem_dout
);

    localparam int ENTRY_W = ADDR_W + 8;

    arb_state_t state;
    arb_state_t state_nxt;

    logic                        cpu_pend;
    logic                        overrun_q;
    logic                        rd_issued;
    logic                        ready_q;
    logic [7:0]                  dout_q;

    logic                        push;
    logic                        pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [ENTRY_W-1:0]          fifo_head;

    logic                        cpu_req;
    logic                        ld_req;
    logic                        cpu_win;

    // ready_q holds ld_ready low while reset is asserted even though the
    // FIFO reads empty.
    assign ld_ready = ready_q & ~fifo_full;
    assign push     = ld_valid & ld_ready;

    // Requests include same-cycle arrivals so an idle arbiter reacts at once:
    // a tick reaches CPU_SETUP next clock, a push into an empty FIFO is
    // written next clock.
    assign cpu_req = cpu_pend | cpu_tick;
    assign ld_req  = ~fifo_empty | push;

`ifdef RAM_ARB_CPU_PRIORITY_EN
    assign cpu_win = cpu_req;
`else
    logic last_grant_ld;

    assign cpu_win = cpu_req & (last_grant_ld | ~ld_req);

    always_ff @(posedge clk7 or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_ld <= 1'b1;
        end else if (state == ST_IDLE) begin
            if (state_nxt == ST_CPU_SETUP)    last_grant_ld <= 1'b0;
            else if (state_nxt == ST_LOAD_WR) last_grant_ld <= 1'b1;
        end
    end
`endif

    apple1_ld_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ld_fifo (
        .clk7    (clk7),
        .reset_n (reset_n),
        .push    (push),
        .wdata   ({ld_addr, ld_data}),
        .pop     (pop),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk7 or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_din   = '0;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        cpu_clken = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_win)     state_nxt = ST_CPU_SETUP;
                else if (ld_req) state_nxt = ST_LOAD_WR;
            end
            ST_CPU_SETUP: begin
                mem_addr  = cpu_addr;
                mem_rd    = cpu_ram_rd & ~cpu_ram_wr;
                state_nxt = ST_CPU_COMMIT;
            end
            ST_CPU_COMMIT: begin
                cpu_clken = 1'b1;
                if (cpu_ram_wr) begin
                    mem_we   = 1'b1;
                    mem_din  = cpu_dout;
                    mem_addr = cpu_addr;
                end
                state_nxt = ST_IDLE;
            end
            ST_LOAD_WR: begin
                mem_we    = 1'b1;
                mem_addr  = fifo_head[ENTRY_W-1:8];
                mem_din   = fifo_head[7:0];
                pop       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk7 or negedge reset_n) begin
        if (!reset_n) begin
            cpu_pend  <= 1'b0;
            overrun_q <= 1'b0;
            rd_issued <= 1'b0;
            ready_q   <= 1'b0;
            dout_q    <= 8'h00;
        end else begin
            ready_q <= 1'b1;
            // SETUP always moves to COMMIT, so clearing here is clearing on
            // entry to COMMIT; a tick landing in SETUP merges into this cycle.
            if (state == ST_CPU_SETUP) cpu_pend <= 1'b0;
            else if (cpu_tick)         cpu_pend <= 1'b1;
            if (cpu_tick && cpu_pend)  overrun_q <= 1'b1;
            rd_issued <= (state == ST_CPU_SETUP) && mem_rd;
            if (state == ST_CPU_COMMIT && rd_issued) dout_q <= mem_dout;
        end
    end

    assign cpu_ram_dout = dout_q;
    assign cpu_overrun  = overrun_q;
    assign ld_busy      = (fifo_count != '0) || (state == ST_LOAD_WR);

endmodule

// File: tb/tb_apple1_ram_arbiter.sv
// tb_apple1_ram_arbiter
// Directed bench for apple1_ram_arbiter (default round-robin build). A small
// synchronous RAM model answers the RAM port; a negedge recorder logs every
// cpu_clken, mem_rd and mem_we with its cycle number for the scenario tasks.
module tb_apple1_ram_arbiter;
    import apple1_ram_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_tick = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_ram_rd = 1'b0;
    logic        cpu_ram_wr = 1'b0;
    logic [7:0]  cpu_ram_dout;
    logic        cpu_clken;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [15:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_busy;
    logic        cpu_overrun;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_rd;
    logic        mem_we;
    logic [7:0]  mem_dout = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int both_cnt = 0;

    typedef struct {
        int          c;
        logic [15:0] a;
        logic [7:0]  d;
    } wr_rec_t;

    wr_rec_t     we_log[$];
    int          clken_log[$];
    int          rd_log[$];
    logic [7:0]  ram [65536];

    apple1_ram_arbiter dut (
        .clk7         (clk),
        .reset_n      (reset_n),
        .cpu_tick     (cpu_tick),
        .cpu_addr     (cpu_addr),
        .cpu_dout     (cpu_dout),
        .cpu_ram_rd   (cpu_ram_rd),
        .cpu_ram_wr   (cpu_ram_wr),
        .cpu_ram_dout (cpu_ram_dout),
        .cpu_clken    (cpu_clken),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_busy      (ld_busy),
        .cpu_overrun  (cpu_overrun),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_rd       (mem_rd),
        .mem_we       (mem_we),
        .mem_dout     (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        if (mem_rd) mem_dout <= ram[mem_addr];
    end

    always @(negedge clk) begin
        wr_rec_t r;
        if (cpu_clken) clken_log.push_back(cyc);
        if (mem_rd) rd_log.push_back(cyc);
        if (mem_we) begin
            r.c = cyc;
            r.a = mem_addr;
            r.d = mem_din;
            we_log.push_back(r);
        end
        if (mem_we && mem_rd) both_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        clken_log.delete();
        we_log.delete();
        rd_log.delete();
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if ({mem_addr, mem_din, mem_rd, mem_we} !== 26'h0) begin
            errors++;
            $display("FAIL reset_mem: got %h %h %b %b exp all zero", mem_addr, mem_din, mem_rd, mem_we);
        end
        checks++;
        if ({cpu_clken, cpu_ram_dout} !== 9'h000) begin
            errors++;
            $display("FAIL reset_cpu: got clken %b dout %h exp 0 00", cpu_clken, cpu_ram_dout);
        end
        checks++;
        if ({ld_ready, ld_busy, cpu_overrun} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: got ready %b busy %b ovr %b exp 0 0 0", ld_ready, ld_busy, cpu_overrun);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b exp 1", ld_ready);
        end
        repeat (2) step();
    endtask

    task automatic test_cpu_read();
        int t;
        int got;
        // preload RAM through the loader port
        ld_valid = 1'b1; ld_addr = 16'h0300; ld_data = 8'hA5;
        step();
        ld_valid = 1'b0;
        repeat (3) step();
        clear_logs();
        t = cyc;
        cpu_tick = 1'b1; cpu_addr = 16'h0300; cpu_ram_rd = 1'b1;
        step();
        cpu_tick = 1'b0;
        step();
        checks++;
        if (cpu_ram_dout !== 8'h00) begin
            errors++;
            $display("FAIL read_early_dout: got %h exp 00", cpu_ram_dout);
        end
        step();
        checks++;
        if (cpu_ram_dout !== 8'hA5) begin
            errors++;
            $display("FAIL read_dout: got %h exp a5", cpu_ram_dout);
        end
        repeat (3) step();
        cpu_ram_rd = 1'b0;
        got = (clken_log.size() == 1) ? clken_log[0] - t : -1;
        checks++;
        if (got !== 2) begin
            errors++;
            $display("FAIL read_clken_cycle: got T+%0d exp T+2", got);
        end
        got = (rd_log.size() == 1) ? rd_log[0] - t : -1;
        checks++;
        if (got !== 1) begin
            errors++;
            $display("FAIL read_mem_rd_cycle: got T+%0d exp T+1", got);
        end
    endtask

    task automatic test_cpu_write();
        int t;
        int got;
        clear_logs();
        t = cyc;
        cpu_tick = 1'b1; cpu_addr = 16'h0280; cpu_dout = 8'h3C; cpu_ram_wr = 1'b1;
        step();
        cpu_tick = 1'b0;
        repeat (5) step();
        cpu_ram_wr = 1'b0;
        got = (we_log.size() == 1) ? we_log[0].c - t : -1;
        checks++;
        if (got !== 2) begin
            errors++;
            $display("FAIL write_we_cycle: got T+%0d (count %0d) exp T+2 count 1", got, we_log.size());
        end
        got = (clken_log.size() == 1) ? clken_log[0] - t : -1;
        checks++;
        if (got !== 2) begin
            errors++;
            $display("FAIL write_clken_cycle: got T+%0d exp T+2", got);
        end
        checks++;
        if (ram[16'h0280] !== 8'h3C) begin
            errors++;
            $display("FAIL write_ram: got %h exp 3c", ram[16'h0280]);
        end
        checks++;
        if (rd_log.size() !== 0) begin
            errors++;
            $display("FAIL write_no_read: got %0d reads exp 0", rd_log.size());
        end
    endtask

    task automatic test_io_cycle();
        int t;
        int got;
        clear_logs();
        t = cyc;
        cpu_tick = 1'b1; cpu_addr = 16'hD012;
        step();
        cpu_tick = 1'b0;
        repeat (5) step();
        got = (clken_log.size() == 1) ? clken_log[0] - t : -1;
        checks++;
        if (got !== 2) begin
            errors++;
            $display("FAIL io_clken_cycle: got T+%0d exp T+2", got);
        end
        checks++;
        if (rd_log.size() + we_log.size() !== 0) begin
            errors++;
            $display("FAIL io_no_strobes: got %0d strobes exp 0", rd_log.size() + we_log.size());
        end
        checks++;
        if (cpu_ram_dout !== 8'hA5) begin
            errors++;
            $display("FAIL io_dout_hold: got %h exp a5", cpu_ram_dout);
        end
    endtask

    task automatic test_loader_burst();
        ld_entry_t ents [8];
        int acc [8];
        int exp_acc [8];
        int i;
        int t;
        int ready_low;
        for (int k = 0; k < 8; k++) begin
            ents[k].addr = 16'(k);
            ents[k].data = 8'(8'h10 + k);
            acc[k] = -1;
        end
        // one LOAD_WR per two clocks drains slower than a one-per-clock host:
        // the FIFO reaches 4 in cycle 7, so entry 7 waits one clock
        exp_acc = '{0, 1, 2, 3, 4, 5, 6, 8};
        clear_logs();
        i = 0;
        ready_low = -1;
        t = cyc;
        for (int k = 0; k < 40 && i < 8; k++) begin
            ld_valid = 1'b1; ld_addr = ents[i].addr; ld_data = ents[i].data;
            if (ld_ready) begin
                acc[i] = cyc - t;
                i++;
            end else if (ready_low < 0) begin
                ready_low = cyc - t;
            end
            step();
        end
        ld_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (acc[k] !== exp_acc[k]) begin
                errors++;
                $display("FAIL burst_accept_%0d: got T+%0d exp T+%0d", k, acc[k], exp_acc[k]);
            end
        end
        checks++;
        if (ready_low !== 7) begin
            errors++;
            $display("FAIL burst_ready_low: got T+%0d exp T+7", ready_low);
        end
        while (cyc < t + 15) step();
        checks++;
        if ({mem_we, ld_busy} !== 2'b11) begin
            errors++;
            $display("FAIL burst_last_we: got we %b busy %b exp 1 1", mem_we, ld_busy);
        end
        step();
        checks++;
        if (ld_busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_busy_fall: got %b exp 0", ld_busy);
        end
        checks++;
        if (we_log.size() !== 8) begin
            errors++;
            $display("FAIL burst_we_count: got %0d exp 8", we_log.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (we_log[k].a !== ents[k].addr || we_log[k].d !== ents[k].data ||
                    we_log[k].c - t !== 2 * k + 1) begin
                    errors++;
                    $display("FAIL burst_write_%0d: got %h<=%h at T+%0d exp %h<=%h at T+%0d", k,
                             we_log[k].a, we_log[k].d, we_log[k].c - t,
                             ents[k].addr, ents[k].data, 2 * k + 1);
                end
            end
        end
        repeat (2) step();
    endtask

    task automatic test_contention();
        int t;
        int got;
        // last grant was the loader, so the CPU takes this contention
        clear_logs();
        t = cyc;
        cpu_tick = 1'b1;
        ld_valid = 1'b1; ld_addr = 16'h0100; ld_data = 8'h55;
        step();
        cpu_tick = 1'b0;
        ld_addr = 16'h0101; ld_data = 8'h66;
        step();
        ld_valid = 1'b0;
        repeat (8) step();
        got = (clken_log.size() == 1) ? clken_log[0] - t : -1;
        checks++;
        if (got !== 2) begin
            errors++;
            $display("FAIL cont_clken: got T+%0d exp T+2", got);
        end
        checks++;
        if (we_log.size() !== 2) begin
            errors++;
            $display("FAIL cont_we_count: got %0d exp 2", we_log.size());
        end else begin
            checks++;
            if (we_log[0].c - t !== 4 || we_log[0].a !== 16'h0100 || we_log[0].d !== 8'h55 ||
                we_log[1].c - t !== 6 || we_log[1].a !== 16'h0101 || we_log[1].d !== 8'h66) begin
                errors++;
                $display("FAIL cont_we_order: got %h<=%h T+%0d, %h<=%h T+%0d exp 0100<=55 T+4, 0101<=66 T+6",
                         we_log[0].a, we_log[0].d, we_log[0].c - t,
                         we_log[1].a, we_log[1].d, we_log[1].c - t);
            end
        end
    endtask

    task automatic test_round_robin();
        int t;
        int got;
        logic ok;
        clear_logs();
        // lone CPU cycle leaves the CPU as last owner
        cpu_tick = 1'b1;
        step();
        cpu_tick = 1'b0;
        step();
        step();
        t = cyc;
        cpu_tick = 1'b1;
        ld_valid = 1'b1; ld_addr = 16'h0110; ld_data = 8'h77;
        step();
        cpu_tick = 1'b0;
        ld_valid = 1'b0;
        repeat (8) step();
        got = (we_log.size() == 1) ? we_log[0].c - t : -1;
        checks++;
        if (got !== 1) begin
            errors++;
            $display("FAIL rr_loader_first: got T+%0d exp T+1", got);
        end
        ok = (clken_log.size() == 2) && (we_log.size() == 1) && (clken_log[1] > we_log[0].c);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL rr_cpu_after_loader: got clken count %0d exp 2 with second after write", clken_log.size());
        end
    endtask

    task automatic test_overrun();
        int t;
        int got;
        clear_logs();
        t = cyc;
        ld_valid = 1'b1; ld_addr = 16'h0120; ld_data = 8'h99;
        step();
        ld_valid = 1'b0;
        cpu_tick = 1'b1;
        checks++;
        if ({mem_we, cpu_overrun} !== 2'b10) begin
            errors++;
            $display("FAIL ovr_setup: got we %b ovr %b exp 1 0", mem_we, cpu_overrun);
        end
        step();
        step();
        cpu_tick = 1'b0;
        repeat (8) step();
        got = (clken_log.size() == 1) ? clken_log[0] - t : -1;
        checks++;
        if (got !== 4) begin
            errors++;
            $display("FAIL ovr_single_clken: got T+%0d (count %0d) exp T+4 count 1", got, clken_log.size());
        end
        checks++;
        if (cpu_overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_flag: got %b exp 1", cpu_overrun);
        end
        repeat (5) step();
        checks++;
        if (cpu_overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: got %b exp 1", cpu_overrun);
        end
    endtask

    task automatic test_reset_mid();
        int acc_cnt;
        clear_logs();
        acc_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            ld_valid = 1'b1; ld_addr = 16'(16'h0200 + k); ld_data = 8'(8'hA0 + k);
            if (ld_ready) acc_cnt++;
            step();
        end
        ld_valid = 1'b0;
        // cycle 5: entry 2 being written, 3 entries queued
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, ld_busy, ld_ready, cpu_overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_status: got we %b busy %b ready %b ovr %b exp 0 0 0 0",
                     mem_we, ld_busy, ld_ready, cpu_overrun);
        end
        checks++;
        if (acc_cnt !== 5) begin
            errors++;
            $display("FAIL rst_mid_accepted: got %0d exp 5", acc_cnt);
        end
        step();
        step();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if ({ld_ready, ld_busy, cpu_ram_dout} !== 10'b10_0000_0000) begin
            errors++;
            $display("FAIL rst_mid_release: got ready %b busy %b dout %h exp 1 0 00", ld_ready, ld_busy, cpu_ram_dout);
        end
        repeat (6) step();
        checks++;
        if (we_log.size() !== 2) begin
            errors++;
            $display("FAIL rst_mid_no_write: got %0d writes exp 2", we_log.size());
        end
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL strobe_overlap: got %0d exp 0", both_cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_io_cycle();
        test_loader_burst();
        test_contention();
        test_round_robin();
        test_overrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
